// File: rtl/line_enc_pkg.sv
// Shared types, defaults and the priority helper for the line encoder.
package line_enc_pkg;

    localparam int LE_N_LINES = 8;
    localparam int LE_CODE_W  = 3;

    // FSM states
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } le_state_e;

    // Index of the winning set bit in an 8-bit mask.
    // Narrower masks are zero-extended by the caller, so unused upper
    // lines never win. An empty mask returns 0.
    function automatic logic [2:0] prio(input logic [7:0] mask, input bit hi_prio);
        logic [2:0] idx;
        idx = 3'd0;
        if (hi_prio) begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (mask[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/line_encoder_8to3_prio.sv
// Combinational priority encoder over the pending mask.
// HI_PRIO=1: highest set index wins; HI_PRIO=0: lowest set index wins.
module line_prio_enc
    import line_enc_pkg::*;
#(
    parameter int N_LINES = LE_N_LINES,
    parameter int CODE_W  = LE_CODE_W,
    parameter int HI_PRIO = 1
) (
    input  logic [N_LINES-1:0] i_mask,
    output logic [CODE_W-1:0]  o_index,
    output logic               o_any
);

    logic [7:0] w_mask8;
    logic [2:0] w_idx8;

    // Widen to the 8-line helper and narrow the result back to CODE_W.
    always_comb begin
        w_mask8 = 8'(i_mask);
        w_idx8  = prio(w_mask8, HI_PRIO != 0);
        o_index = w_idx8[CODE_W-1:0];
        o_any   = |i_mask;
    end

endmodule

// File: rtl/line_encoder_8to3.sv
// Registered 8-to-3 priority request encoder with enable cascade.
// Active-low request lines are captured into a sticky pending mask; the
// winning line is presented as a binary code over valid/ready.
// Build option: LINE_ENC_SYNC_EN adds a 2-flop synchronizer (reset to ones)
// on in_n and ei_n, adding two cycles of latency.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no code offered; loads prio(pending) when pending is non-zero
// HOLD  | out_code/out_valid held stable until the consumer's out_ready
module line_encoder_8to3
    import line_enc_pkg::*;
#(
    parameter int N_LINES = LE_N_LINES,  // power of two, 2..8
    parameter int CODE_W  = LE_CODE_W,   // must equal $clog2(N_LINES)
    parameter int HI_PRIO = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ei_n,
    input  logic [N_LINES-1:0] in_n,
    input  logic               clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_code,
    output logic               gs_n,
    output logic               eo_n
);

    logic [N_LINES-1:0] w_in_n;
    logic               w_ei_n;

`ifdef LINE_ENC_SYNC_EN
    logic [N_LINES-1:0] r_in_meta;
    logic [N_LINES-1:0] r_in_sync;
    logic               r_ei_meta;
    logic               r_ei_sync;

    // Two-stage synchronizer; idle (all ones) out of reset so nothing is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_meta <= '1;
            r_in_sync <= '1;
            r_ei_meta <= 1'b1;
            r_ei_sync <= 1'b1;
        end else begin
            r_in_meta <= in_n;
            r_in_sync <= r_in_meta;
            r_ei_meta <= ei_n;
            r_ei_sync <= r_ei_meta;
        end
    end

    assign w_in_n = r_in_sync;
    assign w_ei_n = r_ei_sync;
`else
    assign w_in_n = in_n;
    assign w_ei_n = ei_n;
`endif

    le_state_e          r_state;
    le_state_e          w_state_nxt;
    logic [N_LINES-1:0] r_pending;
    logic [N_LINES-1:0] w_pend_nxt;
    logic               r_out_valid;
    logic               w_valid_nxt;
    logic [CODE_W-1:0]  r_out_code;
    logic [CODE_W-1:0]  w_code_nxt;
    logic               r_gs_n;
    logic               r_eo_n;
    logic               w_gs_nxt;
    logic               w_eo_nxt;

    logic [CODE_W-1:0]  w_prio_idx;
    logic               w_any;
    logic               w_hs;
    logic [N_LINES-1:0] w_set;
    logic [N_LINES-1:0] w_clr_mask;

    line_prio_enc #(
        .N_LINES (N_LINES),
        .CODE_W  (CODE_W),
        .HI_PRIO (HI_PRIO)
    ) u_prio (
        .i_mask  (r_pending),
        .o_index (w_prio_idx),
        .o_any   (w_any)
    );

    // New requests and the bit retired by a handshake this cycle.
    always_comb begin
        w_hs       = r_out_valid & out_ready;
        w_set      = w_ei_n ? '0 : ~w_in_n;
        w_clr_mask = w_hs ? ({{(N_LINES-1){1'b0}}, 1'b1} << r_out_code) : '0;
    end

    // Next-state logic; a same-cycle set of the retired bit survives the clear.
    always_comb begin
        w_pend_nxt  = (r_pending & ~w_clr_mask) | w_set;
        w_state_nxt = r_state;
        w_valid_nxt = r_out_valid;
        w_code_nxt  = r_out_code;
        if (clr) begin
            w_pend_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_code_nxt  = w_prio_idx;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
        w_gs_nxt = ~((|w_pend_nxt) | w_valid_nxt);
        w_eo_nxt = ~(~w_ei_n & (&w_in_n) & ~(|w_pend_nxt));
    end

    // State, pending mask and registered cascade outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_gs_n      <= 1'b1;
            r_eo_n      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pend_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_code  <= w_code_nxt;
            r_gs_n      <= w_gs_nxt;
            r_eo_n      <= w_eo_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign gs_n      = r_gs_n;
    assign eo_n      = r_eo_n;

endmodule

// File: doc/line_encoder_8to3.md
Name: line_encoder_8to3

Overview:
- Registered 8-to-3 priority request encoder with enable cascade, in the 74148 style.
- It is the inverse of the active-low 3-to-8 line decoder family. Eight active-low request lines are captured into a sticky pending mask.
- The highest-priority pending line is presented as a 3-bit code over a valid/ready handshake.
- Sits between decoded select/interrupt lines and a consumer that needs a binary index.

Parameters:
- N_LINES, 8, number of request lines. Must be a power of two, 2..8.
- CODE_W, 3, code width. Must equal $clog2(N_LINES).
- HI_PRIO, 1, 1 = highest index wins; 0 = lowest index wins.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ei_n  in  1  active-low enable in. High blocks capture of new requests.
- in_n  in  N_LINES  active-low request lines, level-sensitive.
- clr  in  1  synchronous flush of pending mask and output stage.
- out_valid  out  1  code available.
- out_ready  in  1  consumer accepts code.
- out_code  out  CODE_W  encoded index of the served line.
- gs_n  out  1  registered active-low group select: low when any pending bit is set or out_valid=1.
- eo_n  out  1  registered active-low enable out: low when ei_n=0, in_n all ones and pending=0 (cascade to the next lower encoder).

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, state=IDLE.
  - out_valid=0, out_code=0.
  - gs_n=1, eo_n=1.
  - Deassertion is synchronous to clk.
- Capture: each edge, pending[i] <= pending[i] | (~ei_n & ~in_n[i]). ei_n=1 freezes capture but never clears pending.
- FSM with two states:
  - IDLE: if pending!=0 and clr=0, load out_code=prio(pending) and set out_valid=1, then go to HOLD. Otherwise stay in IDLE.
  - HOLD: out_valid and out_code are held stable until out_ready=1. On handshake (out_valid & out_ready):
    - clear pending[out_code];
    - drop out_valid;
    - go to IDLE.
- Latency: request sampled at edge k, pending set at k+1, out_valid high after k+2.
- Throughput: one code per 2 cycles, with a mandatory idle bubble after each handshake.
- Simultaneous set and clear of the same bit on a handshake cycle: set wins, and the line is re-served later.
- Priority is evaluated only at the IDLE->HOLD load. Higher-priority arrivals during HOLD do not preempt the held code.
- clr=1 (highest priority after reset):
  - pending <= 0, out_valid <= 0, state <= IDLE.
  - Capture in the same cycle is discarded.
  - A held code is dropped without a handshake; this is the only legal valid-withdrawal.
- gs_n and eo_n are registered from next-state values, so they align with pending and out_valid.
- out_code is not required to hold a meaningful value when out_valid=0.

Optional Feature:
- Macro: LINE_ENC_SYNC_EN.
- Defined: in_n and ei_n pass through a 2-flop synchronizer reset to all ones before capture. Latency grows by 2 cycles (valid at k+4), and eo_n follows the synchronized values.
- Undefined: inputs are captured directly and the caller guarantees they are synchronous to clk.

Decomposition:
- Package line_enc_pkg holds:
  - state enum (IDLE, HOLD);
  - default N_LINES and CODE_W localparams;
  - a prio function (mask, hi_prio) -> index.
- One sub-module: line_prio_enc, purely combinational. It takes mask in and returns index plus any_set, honouring HI_PRIO.
- Register, FSM and synchronizer logic stay in the top module.

Test Plan:
- Reset mid-HOLD:
  - Stimulus: in_n=8'b1111_0111, ei_n=0, out_ready=0; assert rst_n=0 while out_valid=1.
  - Response: out_valid=0, gs_n=1, eo_n=1 immediately, with no clock edge needed.
  - After release with in_n=8'hFF, no code is produced.
- Single request:
  - Stimulus: pulse in_n=8'b1101_1111 for 1 cycle, out_ready=1.
  - Response: out_valid rises 2 cycles later with out_code=5, then handshake, pending=0, gs_n=1.
- Priority order:
  - Stimulus: in_n=8'b0111_1110 for 1 cycle, HI_PRIO=1, out_ready=1.
  - Response: codes 7 then 0 on consecutive handshakes with one bubble between them.
  - With HI_PRIO=0 the order is 0 then 7.
- Backpressure plus re-assert:
  - Stimulus: request line 3 while out_ready=0 for 5 cycles, with out_code=3 held.
  - Re-assert in_n[3]=0 on the handshake cycle.
  - Response: code 3 is delivered twice.
- Enable and cascade:
  - ei_n=1 with in_n=8'h00: no capture, eo_n=1, gs_n=1.
  - ei_n=0 with in_n=8'hFF and empty pending: eo_n=0 after 1 edge.
- clr during HOLD:
  - Stimulus: lines 2 and 6 pending, out_code=6 valid; clr=1 for 1 cycle.
  - Response: out_valid=0 and pending=0 the next cycle, and no code 2 is ever emitted.
